// File: rtl/axis_downsizer.sv
// AXI-Stream width downsizer: takes one wide slave beat of DATA_RATIO lanes
// and replays its kept lanes, lane 0 first, as narrow master beats.
module axis_downsizer #(
    parameter int DATA_WIDTH   = 8,
    parameter int DATA_RATIO   = 8,
    parameter int S_DATA_WIDTH = DATA_RATIO * DATA_WIDTH,
    parameter int M_DATA_WIDTH = DATA_WIDTH
) (
    input  logic                    aclk,
    input  logic                    areset,
    input  logic [S_DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [DATA_RATIO-1:0]   s_axis_tkeep,
    input  logic                    s_axis_tvalid,
    input  logic                    s_axis_tlast,
    output logic                    s_axis_tready,
    output logic [M_DATA_WIDTH-1:0] m_axis_tdata,
    output logic                    m_axis_tvalid,
    output logic                    m_axis_tlast,
    input  logic                    m_axis_tready
);

    localparam int IDX_W = ($clog2(DATA_RATIO) > 0) ? $clog2(DATA_RATIO) : 1;

    typedef enum logic {
        EMPTY,
        HOLD
    } state_t;

    state_t                  state;
    state_t                  state_next;

    logic [S_DATA_WIDTH-1:0] hold_data;
    logic                    hold_last;
    logic [IDX_W-1:0]        last_idx;   // N-1 of the held word
    logic [IDX_W-1:0]        idx;
    logic [IDX_W-1:0]        keep_last;  // N-1 derived from the incoming tkeep
    logic                    keep_run;

    logic                    last_lane;
    logic                    capture;
    logic                    m_fire;
    logic                    drain;

    assign last_lane = (idx == last_idx);
    assign capture   = s_axis_tvalid && s_axis_tready;
    assign m_fire    = m_axis_tvalid && m_axis_tready;
    assign drain     = m_fire && last_lane;

    // Lane count: highest index reached by the unbroken run of ones from lane 0
    // (lane 0 is always emitted, so an all-zero keep still yields one lane).
    always_comb begin
        keep_last = '0;
        keep_run  = 1'b1;
        for (int unsigned i = 0; i < DATA_RATIO; i++) begin
            keep_run = keep_run & s_axis_tkeep[i];
            if (keep_run) begin
                keep_last = IDX_W'(i);
            end
        end
    end

    // State register.
    always_ff @(posedge aclk) begin
        if (areset) begin
            state <= EMPTY;
        end else begin
            state <= state_next;
        end
    end

    // Next-state: a capture always leaves us holding; a drain only empties when
    // no new word arrives in the same cycle.
    always_comb begin
        state_next = state;
        case (state)
            EMPTY:   if (capture) state_next = HOLD;
            HOLD:    if (drain && !capture) state_next = EMPTY;
            default: state_next = EMPTY;
        endcase
    end

    // Handshake outputs, forced low while reset is asserted.
    always_comb begin
        s_axis_tready = 1'b0;
        m_axis_tvalid = 1'b0;
        m_axis_tlast  = 1'b0;
        if (!areset) begin
            case (state)
                EMPTY: begin
                    s_axis_tready = 1'b1;
                end
                HOLD: begin
                    m_axis_tvalid = 1'b1;
                    m_axis_tlast  = hold_last && last_lane;
                    s_axis_tready = m_axis_tready && last_lane;
                end
                default: begin
                    s_axis_tready = 1'b0;
                end
            endcase
        end
    end

    // Holding register and lane index; the data word itself needs no reset.
    always_ff @(posedge aclk) begin
        if (areset) begin
            hold_last <= 1'b0;
            last_idx  <= '0;
            idx       <= '0;
        end else if (capture) begin
            hold_data <= s_axis_tdata;
            hold_last <= s_axis_tlast;
            last_idx  <= keep_last;
            idx       <= '0;
        end else if (m_fire) begin
            idx <= last_lane ? '0 : idx + IDX_W'(1);
        end
    end

    // Present the current lane of the held word.
    always_comb begin
        m_axis_tdata = M_DATA_WIDTH'(hold_data[idx*DATA_WIDTH +: DATA_WIDTH]);
    end

endmodule

// File: tb/tb_axis_downsizer.sv
// Testbench for axis_downsizer (DATA_WIDTH=8, DATA_RATIO=4): directed
// scenarios plus randomized traffic against a lane-queue scoreboard.
module tb_axis_downsizer;

    localparam int DW = 8;
    localparam int R  = 4;

    logic            aclk = 1'b0;
    logic            areset;
    logic [DW*R-1:0] s_data;
    logic [R-1:0]    s_keep;
    logic            s_valid;
    logic            s_last;
    logic            s_ready;
    logic [DW-1:0]   m_data;
    logic            m_valid;
    logic            m_last;
    logic            m_ready;

    int checks   = 0;
    int failures = 0;

    axis_downsizer #(
        .DATA_WIDTH (DW),
        .DATA_RATIO (R)
    ) dut (
        .aclk          (aclk),
        .areset        (areset),
        .s_axis_tdata  (s_data),
        .s_axis_tkeep  (s_keep),
        .s_axis_tvalid (s_valid),
        .s_axis_tlast  (s_last),
        .s_axis_tready (s_ready),
        .m_axis_tdata  (m_data),
        .m_axis_tvalid (m_valid),
        .m_axis_tlast  (m_last),
        .m_axis_tready (m_ready)
    );

    always #5 aclk = ~aclk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: every accepted wide beat becomes a list of narrow beats
    // (its kept lanes); the sink must see exactly that list, in order.
    typedef struct packed {
        logic [DW-1:0] d;
        logic          l;
    } beat_t;

    beat_t exp_q[$];
    int    pushed    = 0;
    int    dropped   = 0;
    int    dut_beats = 0;

    function automatic int lanes_of(input logic [R-1:0] k);
        int n = 0;
        while (n < R && k[n]) n++;
        return (n == 0) ? 1 : n;
    endfunction

    always @(negedge aclk) begin
        if (areset) begin
            check_eq("rst_s_ready", s_ready, 0);
            check_eq("rst_m_valid", m_valid, 0);
            check_eq("rst_m_last", m_last, 0);
            dropped += exp_q.size();
            exp_q.delete();
        end else begin
            check_eq("mon_m_valid", m_valid, exp_q.size() > 0);
            check_eq("mon_s_ready", s_ready, (exp_q.size() == 0) || (exp_q.size() == 1 && m_ready));
            if (exp_q.size() > 0) begin
                check_eq("mon_m_data", m_data, exp_q[0].d);
                check_eq("mon_m_last", m_last, exp_q[0].l);
            end
            if (m_valid && m_ready) begin
                dut_beats++;
                if (exp_q.size() > 0) void'(exp_q.pop_front());
            end
            if (s_valid && s_ready) begin
                int n;
                n = lanes_of(s_keep);
                for (int i = 0; i < n; i++) begin
                    exp_q.push_back('{d: s_data[i*DW +: DW], l: s_last && (i == n - 1)});
                    pushed++;
                end
            end
        end
    end

    // Directed stream driver: feeds the in_* words back to back, follows
    // rdy_mask for the sink, and logs the per-cycle outputs.
    logic [DW*R-1:0] in_d[$];
    logic [R-1:0]    in_k[$];
    logic            in_l[$];
    logic [63:0]     rdy_mask;
    logic [DW-1:0]   ob_d[$];
    logic            ob_l[$];
    int              ob_c[$];
    logic            srdy[$];
    logic            mv[$];
    logic [DW-1:0]   md[$];

    task automatic stream(input int ncyc);
        int w;
        bit hs;
        w = 0;
        ob_d.delete(); ob_l.delete(); ob_c.delete();
        srdy.delete(); mv.delete(); md.delete();
        m_ready = rdy_mask[0];
        if (in_d.size() > 0) begin
            s_valid = 1'b1; s_data = in_d[0]; s_keep = in_k[0]; s_last = in_l[0];
        end
        for (int c = 0; c < ncyc; c++) begin
            @(negedge aclk);
            srdy.push_back(s_ready);
            mv.push_back(m_valid);
            md.push_back(m_data);
            if (m_valid && m_ready) begin
                ob_d.push_back(m_data); ob_l.push_back(m_last); ob_c.push_back(c);
            end
            hs = s_valid && s_ready;
            @(posedge aclk); #1;
            if (hs) begin
                w++;
                if (w < in_d.size()) begin
                    s_data = in_d[w]; s_keep = in_k[w]; s_last = in_l[w];
                end else begin
                    s_valid = 1'b0;
                end
            end
            m_ready = rdy_mask[c + 1];
        end
        s_valid = 1'b0;
        m_ready = 1'b1;
    endtask

    task automatic set_words1(input logic [DW*R-1:0] d, input logic [R-1:0] k, input logic l);
        in_d.delete(); in_k.delete(); in_l.delete();
        in_d.push_back(d); in_k.push_back(k); in_l.push_back(l);
    endtask

    initial begin
        bit hs;
        int wait_cyc;
        areset = 1'b1; s_valid = 1'b0; s_data = '0; s_keep = '0; s_last = 1'b0; m_ready = 1'b0;
        repeat (3) @(posedge aclk);
        #1;
        @(negedge aclk);
        check_eq("reset_s_ready", s_ready, 0);
        check_eq("reset_m_valid", m_valid, 0);
        @(posedge aclk); #1;
        areset = 1'b0;
        @(negedge aclk);
        check_eq("post_reset_s_ready", s_ready, 1);
        check_eq("post_reset_m_valid", m_valid, 0);
        @(posedge aclk); #1;

        // Scenario 1: single full word.
        set_words1(32'h44332211, 4'hF, 1'b1);
        rdy_mask = '1;
        stream(7);
        check_eq("s1_beats", ob_d.size(), 4);
        if (ob_d.size() == 4) begin
            for (int i = 0; i < 4; i++) begin
                check_eq("s1_data", ob_d[i], 8'h11 * (i + 1));
                check_eq("s1_last", ob_l[i], i == 3);
                check_eq("s1_cycle", ob_c[i], i + 1);
            end
        end
        for (int c = 1; c <= 3; c++) check_eq("s1_s_ready_low", srdy[c], 0);
        check_eq("s1_s_ready_drain", srdy[4], 1);

        // Scenario 2: back-to-back words, zero bubble.
        in_d.delete(); in_k.delete(); in_l.delete();
        in_d.push_back(32'h44332211); in_k.push_back(4'hF); in_l.push_back(1'b0);
        in_d.push_back(32'h88776655); in_k.push_back(4'hF); in_l.push_back(1'b1);
        rdy_mask = '1;
        stream(11);
        check_eq("s2_beats", ob_d.size(), 8);
        if (ob_d.size() == 8) begin
            for (int i = 0; i < 8; i++) begin
                check_eq("s2_data", ob_d[i], 8'h11 * (i + 1));
                check_eq("s2_last", ob_l[i], i == 7);
                check_eq("s2_cycle", ob_c[i], i + 1);
            end
        end

        // Scenario 3: partial keep, then all-zero keep.
        in_d.delete(); in_k.delete(); in_l.delete();
        in_d.push_back(32'hDDCCBBAA); in_k.push_back(4'h3); in_l.push_back(1'b1);
        in_d.push_back(32'hDDCCBBAA); in_k.push_back(4'h0); in_l.push_back(1'b1);
        rdy_mask = '1;
        stream(6);
        check_eq("s3_beats", ob_d.size(), 3);
        if (ob_d.size() == 3) begin
            check_eq("s3_d0", ob_d[0], 8'hAA); check_eq("s3_l0", ob_l[0], 0);
            check_eq("s3_d1", ob_d[1], 8'hBB); check_eq("s3_l1", ob_l[1], 1);
            check_eq("s3_d2", ob_d[2], 8'hAA); check_eq("s3_l2", ob_l[2], 1);
            check_eq("s3_c2", ob_c[2], 3);
        end

        // Scenario 4: sink stalls three cycles on lane 1.
        set_words1(32'h44332211, 4'hF, 1'b1);
        rdy_mask = ~64'h1C;
        stream(10);
        for (int c = 2; c <= 4; c++) begin
            check_eq("s4_stall_valid", mv[c], 1);
            check_eq("s4_stall_data", md[c], 8'h22);
            check_eq("s4_stall_s_ready", srdy[c], 0);
        end
        check_eq("s4_beats", ob_d.size(), 4);
        if (ob_d.size() == 4) begin
            for (int i = 0; i < 4; i++) check_eq("s4_data", ob_d[i], 8'h11 * (i + 1));
            check_eq("s4_resume_cycle", ob_c[1], 5);
            check_eq("s4_last", ob_l[3], 1);
        end

        // Scenario 5: reset after lane 1 was emitted.
        set_words1(32'h44332211, 4'hF, 1'b1);
        rdy_mask = '1;
        stream(3);
        check_eq("s5_pre_beats", ob_d.size(), 2);
        areset = 1'b1;
        @(negedge aclk);
        check_eq("s5_rst_m_valid", m_valid, 0);
        @(posedge aclk); #1;
        @(posedge aclk); #1;
        areset = 1'b0;
        @(negedge aclk);
        check_eq("s5_post_s_ready", s_ready, 1);
        @(posedge aclk); #1;
        set_words1(32'h00000000, 4'h0, 1'b0);
        in_d.delete(); in_k.delete(); in_l.delete();
        rdy_mask = '1;
        stream(4);
        check_eq("s5_no_stale", ob_d.size(), 0);
        set_words1(32'h88776655, 4'hF, 1'b1);
        stream(6);
        check_eq("s5_new_beats", ob_d.size(), 4);
        if (ob_d.size() > 0) begin
            check_eq("s5_new_first", ob_d[0], 8'h55);
            check_eq("s5_new_cycle", ob_c[0], 1);
        end

        // Scenario 6: randomized traffic with occasional reset.
        dropped = 0; pushed = 0; dut_beats = 0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge aclk);
            hs = s_valid && s_ready;
            @(posedge aclk); #1;
            areset = (c % 700 == 350);
            m_ready = ($urandom_range(0, 3) != 0);
            if (!s_valid || hs) begin
                s_valid = ($urandom_range(0, 2) != 0);
                s_data  = $urandom;
                s_last  = $urandom_range(0, 1);
                s_keep  = R'($urandom);
            end
            if (!s_valid) s_keep = R'($urandom);
        end
        s_valid = 1'b0; m_ready = 1'b1; areset = 1'b0;
        wait_cyc = 0;
        while (exp_q.size() > 0 && wait_cyc < 20) begin
            @(posedge aclk); #1;
            wait_cyc++;
        end
        @(negedge aclk);
        check_eq("s6_drained", exp_q.size(), 0);
        check_eq("s6_beat_count", dut_beats, pushed - dropped);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/axis_downsizer.md
AXIS_DOWNSIZER -- requirements
Module: axis_downsizer

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8, giving the master lane width in bits.
REQ-002 The block SHALL have parameter DATA_RATIO, default 8, giving the number of master beats per slave beat; legal range 2..64.
REQ-003 The block SHALL have parameter S_DATA_WIDTH, default DATA_RATIO*DATA_WIDTH, giving the slave data width.
REQ-004 The block SHALL have parameter M_DATA_WIDTH, default DATA_WIDTH, giving the master data width.
REQ-005 The block SHALL have port aclk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-006 The block SHALL have port areset, input, 1 bit: reset, synchronous and active-high.
REQ-007 The block SHALL have port s_axis_tdata, input, S_DATA_WIDTH bits: wide input beat; lane k is bits [DATA_WIDTH*k +: DATA_WIDTH].
REQ-008 The block SHALL have port s_axis_tkeep, input, DATA_RATIO bits: per-lane valid flags.
REQ-009 The block SHALL have port s_axis_tvalid, input, 1 bit: slave beat valid.
REQ-010 The block SHALL have port s_axis_tlast, input, 1 bit: slave beat ends a packet.
REQ-011 The block SHALL have port s_axis_tready, output, 1 bit: slave beat accepted when tvalid and tready are both high.
REQ-012 The block SHALL have port m_axis_tdata, output, M_DATA_WIDTH bits: narrow output beat.
REQ-013 The block SHALL have port m_axis_tvalid, output, 1 bit: master beat valid.
REQ-014 The block SHALL have port m_axis_tlast, output, 1 bit: master beat ends a packet.
REQ-015 The block SHALL have port m_axis_tready, input, 1 bit: downstream accepts the master beat.

Function
REQ-016 On slave handshake, the block SHALL capture tdata, tlast and lane count N into a holding register.
- N = index of the lowest zero bit of s_axis_tkeep (DATA_RATIO if all ones), minimum 1.
- Lane 0 is always emitted; lanes above the first cleared keep bit are discarded.
REQ-017 The block SHALL track a lane index idx (width clog2(DATA_RATIO), minimum 1 bit).
- idx resets to 0 on each capture.
- idx increments on each master handshake.
REQ-018 The block SHALL drive m_axis_tdata with lane idx of the holding register.
REQ-019 The block SHALL assert m_axis_tvalid whenever the holding register is full.
REQ-020 The block SHALL assert m_axis_tlast only when idx==N-1 and the captured tlast is 1.
REQ-021 The block SHALL treat the current word as finished on a master handshake with idx==N-1.
REQ-022 The block SHALL assert s_axis_tready = !full || (m_axis_tready && idx==N-1), i.e. a new word may be captured in the same cycle the last lane drains, giving zero-bubble throughput.
REQ-023 The block SHALL hold m_axis_tdata, m_axis_tlast and idx stable while m_axis_tvalid=1 and m_axis_tready=0.
REQ-024 Latency: the first master beat of a captured word SHALL be valid the cycle after the slave handshake.
REQ-025 Throughput: sustained output SHALL be one master beat per cycle with no idle cycles between words when the source and sink are always ready.
REQ-026 The block SHALL have states EMPTY and HOLD.
- EMPTY->HOLD on capture.
- HOLD->EMPTY on last-lane drain without a new capture.
- HOLD->HOLD on last-lane drain with a simultaneous capture.
REQ-027 A word with N=1 SHALL occupy exactly one output cycle, behaving as a pass-through with a one-cycle delay.
REQ-028 The s_axis_tkeep value SHALL have no effect while s_axis_tvalid=0.

Reset
REQ-029 While areset=1, the block SHALL drive s_axis_tready=0, m_axis_tvalid=0 and m_axis_tlast=0, with state EMPTY and idx=0.
REQ-030 A reset mid-word SHALL discard the held word and remaining lanes; no stale beat is emitted afterward.
REQ-031 The block SHALL drive s_axis_tready=1 on the first cycle after areset deasserts.
REQ-032 m_axis_tdata after reset SHALL be don't-care while m_axis_tvalid=0.

Verification (DATA_WIDTH=8, DATA_RATIO=4)
REQ-033 Scenario 1: tdata=0x44332211, tkeep=0xF, tlast=1, sink ready -> 0x11, 0x22, 0x33, 0x44 on cycles +1..+4; tlast only on 0x44; s_axis_tready low on cycles +1..+3.
REQ-034 Scenario 2: back-to-back words 0x44332211 then 0x88776655 (tlast=0, then 1), sink ready -> 8 contiguous beats 0x11..0x88 with no gap; tlast only on 0x88.
REQ-035 Scenario 3: tdata=0xDDCCBBAA, tkeep=0x3, tlast=1 -> 2 beats 0xAA, 0xBB with tlast on 0xBB; tkeep=0x0 -> 1 beat 0xAA.
REQ-036 Scenario 4: sink stalls (m_axis_tready=0) for 3 cycles at lane 1 -> 0x22 held stable with tvalid=1; s_axis_tready=0; the sequence resumes correctly when the sink is ready.
REQ-037 Scenario 5: areset pulsed after lane 1 of 0x44332211 is emitted -> tvalid=0 during reset; no 0x33 or 0x44 emitted afterward; the next word starts at lane 0.
REQ-038 Scenario 6: randomized tvalid/tready/tkeep with a scoreboard -> the output stream equals the kept lanes in order with tlast preserved, and no beat is lost or duplicated.
